// File: rtl/bcd_7seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : bcd_7seg_scan_driver
// Description : Multi-digit BCD to 7-segment scan driver. Latches N BCD digits
//               and decimal points into a shadow register, time-multiplexes
//               them onto one shared segment bus with a per-digit enable,
//               blanking gap, leading-zero suppression, selectable polarity
//               and sticky invalid-code detection.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_7seg_scan_driver #(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LEADING  = 1,
    localparam int IDX_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  clr_err,
    output logic [7:0]            seg_out,
    output logic [N_DIGITS-1:0]   an_out,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_tick,
    output logic                  err
);

    localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PRESC_W-1:0]  c_presc_last = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]    c_idx_last   = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0]          c_seg_off    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] c_an_off     = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}}
                                                                        : {N_DIGITS{1'b0}};

    // Illegal configurations are rejected while elaborating
    generate
        if (N_DIGITS < 1 || N_DIGITS > 8 || SCAN_DIV < 2 ||
            BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_param_check
            $error("bcd_7seg_scan_driver: illegal N_DIGITS/SCAN_DIV/BLANK_CYCLES");
        end
    endgenerate

    logic [PRESC_W-1:0]    r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_bcd;
    logic [N_DIGITS-1:0]   r_dp;
    logic                  r_err;
    logic                  r_frame_tick;
    logic [7:0]            r_seg;
    logic [N_DIGITS-1:0]   r_an;

    logic                  w_presc_last;
    logic                  w_idx_last;
    logic                  w_slot_open;
    logic [N_DIGITS-1:0]   w_zero;
    logic [N_DIGITS-1:0]   w_lead_zero;
    logic [3:0]            w_sel_bcd;
    logic                  w_sel_dp;
    logic                  w_sel_lz;
    logic                  w_blank;
    logic                  w_any_bad;
    logic [7:0]            w_seg_raw;
    logic [7:0]            w_seg_next;
    logic [N_DIGITS-1:0]   w_an_active;
    logic [N_DIGITS-1:0]   w_an_next;

    // Segment pattern abcdefg, lit = 1; codes above 9 show a dash
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    assign w_presc_last = (r_presc == c_presc_last);
    assign w_idx_last   = (r_idx == c_idx_last);

    // The first BLANK_CYCLES clocks of each slot keep every digit dark
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_slot_open = 1'b1;
        end else begin : g_blank
            assign w_slot_open = (r_presc >= PRESC_W'(BLANK_CYCLES));
        end
    endgenerate

    // w_lead_zero[k]: shadow digits k..N_DIGITS-1 are all zero (codes 10..15 count as non-zero)
    generate
        for (genvar k = 0; k < N_DIGITS; k++) begin : g_lead_zero
            assign w_zero[k] = (r_bcd[4*k +: 4] == 4'd0);
            if (k == N_DIGITS - 1) begin : g_top
                assign w_lead_zero[k] = w_zero[k];
            end else begin : g_chain
                assign w_lead_zero[k] = w_zero[k] & w_lead_zero[k+1];
            end
        end
    endgenerate

    // Select the shadow nibble, dp and blanking flag of the current digit
    always_comb begin
        w_sel_bcd = 4'd0;
        w_sel_dp  = 1'b0;
        w_sel_lz  = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sel_bcd = r_bcd[4*k +: 4];
                w_sel_dp  = r_dp[k];
                w_sel_lz  = w_lead_zero[k];
            end
        end
    end

    // Flag any incoming nibble outside the BCD range
    always_comb begin
        w_any_bad = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (bcd_in[4*k +: 4] > 4'd9) begin
                w_any_bad = 1'b1;
            end
        end
    end

    // Digit 0 is never blanked; a blanked digit still shows its decimal point
    assign w_blank    = (BLANK_LEADING != 0) && w_sel_lz && (r_idx != '0);
    assign w_seg_raw  = {(w_blank ? 7'b0000000 : f_decode(w_sel_bcd)), w_sel_dp};
    assign w_seg_next = (SEG_ACTIVE_LOW != 0) ? ~w_seg_raw : w_seg_raw;

    // One-hot digit enable, only while scanning and past the blank gap
    always_comb begin
        w_an_active = '0;
        if (enable && w_slot_open) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    w_an_active[k] = 1'b1;
                end
            end
        end
    end

    assign w_an_next = (AN_ACTIVE_LOW != 0) ? ~w_an_active : w_an_active;

    // Prescaler and digit index; frame_tick pulses the cycle after the wrap edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= enable && w_presc_last && w_idx_last;
            if (enable) begin
                if (w_presc_last) begin
                    r_presc <= '0;
                    r_idx   <= w_idx_last ? '0 : r_idx + 1'b1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    // Shadow register and sticky error; a bad load beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd <= '0;
            r_dp  <= '0;
            r_err <= 1'b0;
        end else begin
            if (load) begin
                r_bcd <= bcd_in;
                r_dp  <= dp_in;
            end
            if (load && w_any_bad) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    // Registered pin drivers, one clock behind index and shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= c_seg_off;
            r_an  <= c_an_off;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign seg_out    = r_seg;
    assign an_out     = r_an;
    assign digit_idx  = r_idx;
    assign frame_tick = r_frame_tick;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_7seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_7seg_scan_driver
// Description : Scoreboard bench for bcd_7seg_scan_driver. Stimulus pushes
//               hand-computed expectations tagged with the clock count at
//               which they must hold; a negedge monitor pops and compares.
//               A second instance with inverted segment polarity shares the
//               stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_7seg_scan_driver;

    localparam int KIND_SEG  = 0;
    localparam int KIND_AN   = 1;
    localparam int KIND_IDX  = 2;
    localparam int KIND_ERR  = 3;
    localparam int KIND_FT   = 4;
    localparam int KIND_SEGN = 5;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        clr_err;
    logic [7:0]  seg_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx;
    logic        frame_tick;
    logic        err;
    logic [7:0]  seg_out_n;
    logic [3:0]  an_out_n;
    logic [1:0]  digit_idx_n;
    logic        frame_tick_n;
    logic        err_n;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    bcd_7seg_scan_driver #(
        .N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .bcd_in(bcd_in), .dp_in(dp_in), .clr_err(clr_err),
        .seg_out(seg_out), .an_out(an_out), .digit_idx(digit_idx),
        .frame_tick(frame_tick), .err(err)
    );

    bcd_7seg_scan_driver #(
        .N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut_inv (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .bcd_in(bcd_in), .dp_in(dp_in), .clr_err(clr_err),
        .seg_out(seg_out_n), .an_out(an_out_n), .digit_idx(digit_idx_n),
        .frame_tick(frame_tick_n), .err(err_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int kind, input logic [7:0] exp, input string nm);
        logic [7:0] act;
        case (kind)
            KIND_SEG:  act = seg_out;
            KIND_AN:   act = {4'b0000, an_out};
            KIND_IDX:  act = {6'b000000, digit_idx};
            KIND_ERR:  act = {7'b0000000, err};
            KIND_FT:   act = {7'b0000000, frame_tick};
            default:   act = seg_out_n;
        endcase
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compare every expectation due at this clock count
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                chk(sb[i].kind, sb[i].val, sb[i].name);
                sb.delete(i);
            end
        end
    end

    // Expect a value k rising edges from now
    task automatic expect_at(input int k, input int kind, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + k;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic expect_seg(input int k, input logic [7:0] v, input string nm);
        expect_at(k, KIND_SEG, v, nm);
        expect_at(k, KIND_SEGN, ~v, {nm, "_inv"});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        load    = 1'b0;
        clr_err = 1'b0;
        bcd_in  = 16'h0000;
        dp_in   = 4'b0000;
        step(2);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0] e_an;
        logic [7:0] e_seg;
        int         j;

        // Reset values and scan rotation with an all-zero shadow
        do_reset();
        chk(KIND_SEG,  8'h00, "rst_seg");
        chk(KIND_SEGN, 8'hFF, "rst_seg_inv");
        chk(KIND_AN,   8'h0F, "rst_an");
        chk(KIND_IDX,  8'h00, "rst_idx");
        chk(KIND_ERR,  8'h00, "rst_err");
        chk(KIND_FT,   8'h00, "rst_ft");
        enable = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            j     = k - 1;
            e_an  = ((j % 4) >= 1) ? (8'h0F & ~(8'h01 << ((j / 4) % 4))) : 8'h0F;
            e_seg = (((j / 4) % 4) == 0) ? 8'hFC : 8'h00;
            expect_at(k, KIND_IDX, 8'((k / 4) % 4), "scan_idx");
            expect_at(k, KIND_FT, (k == 16) ? 8'h01 : 8'h00, "scan_ft");
            expect_at(k, KIND_AN, e_an, "scan_an");
            expect_seg(k, e_seg, "scan_seg");
        end
        step(18);

        // Load 0305 with dp on digit 1; digit 1 is an inner zero, digit 3 leads
        do_reset();
        enable = 1'b1;
        load   = 1'b1;
        bcd_in = 16'h0305;
        dp_in  = 4'b0010;
        expect_seg(1,  8'hFC, "load_old_shadow");
        expect_seg(2,  8'hB6, "load_d0_5");
        expect_seg(5,  8'hFD, "load_d1_0dp");
        expect_seg(9,  8'hF2, "load_d2_3");
        expect_seg(13, 8'h00, "load_d3_blank");
        expect_seg(17, 8'hB6, "load_d0_again");
        expect_at(1, KIND_ERR, 8'h00, "load_err_clear");
        step(1);
        load = 1'b0;
        step(17);

        // Invalid codes, clear interplay and dash counting as non-zero
        do_reset();
        enable = 1'b1;
        expect_at(1,  KIND_ERR, 8'h01, "bad_load_sets_err");
        expect_seg(2, 8'h02, "bad_d0_dash");
        expect_at(3,  KIND_ERR, 8'h00, "clr_with_good_load");
        expect_seg(4, 8'h60, "good_d0_1");
        expect_at(4,  KIND_ERR, 8'h01, "set_beats_clr");
        expect_seg(6, 8'h02, "dash_d1_not_blank");
        expect_at(7,  KIND_ERR, 8'h00, "clr_alone");
        expect_at(8,  KIND_ERR, 8'h00, "nine_is_valid");
        expect_seg(9, 8'h00, "d2_leading_blank");
        expect_seg(17, 8'hF6, "d0_9");
        load   = 1'b1;
        bcd_in = 16'h000C;
        step(1);
        load = 1'b0;
        step(1);
        load    = 1'b1;
        clr_err = 1'b1;
        bcd_in  = 16'h0001;
        step(1);
        bcd_in = 16'h00A0;
        step(1);
        load    = 1'b0;
        clr_err = 1'b0;
        step(2);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        load    = 1'b1;
        bcd_in  = 16'h0009;
        step(1);
        load = 1'b0;
        step(10);

        // Enable dropped mid-slot freezes the scan and darkens the digits
        do_reset();
        enable = 1'b1;
        expect_at(6,  KIND_AN,  8'h0D, "en_d1_active");
        expect_at(7,  KIND_AN,  8'h0F, "dis_an_dark");
        expect_at(7,  KIND_IDX, 8'h01, "dis_idx_hold1");
        expect_at(9,  KIND_AN,  8'h0F, "dis_an_dark2");
        expect_at(9,  KIND_IDX, 8'h01, "dis_idx_hold2");
        expect_at(10, KIND_AN,  8'h0D, "reen_an");
        expect_at(10, KIND_IDX, 8'h01, "reen_idx_same");
        expect_at(11, KIND_IDX, 8'h02, "reen_idx_adv");
        expect_at(12, KIND_AN,  8'h0F, "reen_blank_gap");
        step(6);
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        step(5);

        // Asynchronous reset between edges while digit 2 is shown
        do_reset();
        enable = 1'b1;
        load   = 1'b1;
        bcd_in = 16'h0305;
        dp_in  = 4'b0010;
        expect_seg(10, 8'hF2, "pre_arst_seg");
        expect_at(10, KIND_AN,  8'h0B, "pre_arst_an");
        expect_at(10, KIND_IDX, 8'h02, "pre_arst_idx");
        step(1);
        load = 1'b0;
        step(9);
        reset = 1'b1;
        #2;
        chk(KIND_SEG,  8'h00, "arst_seg");
        chk(KIND_SEGN, 8'hFF, "arst_seg_inv");
        chk(KIND_AN,   8'h0F, "arst_an");
        chk(KIND_IDX,  8'h00, "arst_idx");
        chk(KIND_FT,   8'h00, "arst_ft");
        step(1);
        reset = 1'b0;
        #1;
        expect_seg(1, 8'hFC, "arst_shadow_lost");
        expect_at(1, KIND_ERR, 8'h00, "arst_err");
        step(3);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
